// File: rtl/quad_enc_ctrl_if.sv
// Snapshot stream port: one count word per beat, tagged with its channel,
// plus a pulse marking the end of a frame.
interface quad_enc_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_data;
    logic [CH_W-1:0]  out_ch;
    logic             frame_done;

    modport master (
        output out_valid, out_data, out_ch, frame_done,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_ch, frame_done,
        output out_ready
    );
endinterface

// File: rtl/quad_enc_ctrl.sv
// Multi-channel x4 quadrature decoder with atomic snapshot and streamed readout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for sample_req or the internal tick
// SNAP  | one cycle: copy every channel's next count into the snapshot
// SEND  | stream snapshot words 0..NUM_CH-1 over the valid/ready port
module quad_enc_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int SAMPLE_DIV = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] enc_a,
    input  logic [NUM_CH-1:0] enc_b,
    input  logic [NUM_CH-1:0] enc_z,
    input  logic [NUM_CH-1:0] zero_en,
    input  logic              sample_req,
    input  logic              clr_flags,
    quad_enc_ctrl_if.master   outBus,
    output logic              busy,
    output logic [NUM_CH-1:0] dir,
    output logic [NUM_CH-1:0] err,
    output logic              overrun
);
    localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SEND = 2'd2
    } stateT;

    logic [1:0]        rstPipe;
    logic              rstSyncN;
    logic [NUM_CH-1:0] aMeta, aSync, bMeta, bSync, zMeta, zSync;

    logic              primed;
    logic [1:0]        prevAb  [NUM_CH];
    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  cntNext [NUM_CH];
    logic [NUM_CH-1:0] dirNext;
    logic [NUM_CH-1:0] illegal;

    logic              tick;
    logic              trigger;

    stateT             state, stateNext;
    logic              outValid;
    logic              loadSnap;
    logic              advance;
    logic              lastAccept;
    logic              overrunSet;
    logic              frameDone;
    logic [CH_W-1:0]   idx;
    logic [CNT_W-1:0]  snap [NUM_CH];

    // Reset asserts immediately and releases two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstPipe <= '0;
        else        rstPipe <= {rstPipe[0], 1'b1};
    end

    assign rstSyncN = rstPipe[1];

    // Pin synchronizers use raw rst_n so they already track the pins when the core leaves reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aMeta <= '0;
            aSync <= '0;
            bMeta <= '0;
            bSync <= '0;
            zMeta <= '0;
            zSync <= '0;
        end else begin
            aMeta <= enc_a;
            aSync <= aMeta;
            bMeta <= enc_b;
            bSync <= bMeta;
            zMeta <= enc_z;
            zSync <= zMeta;
        end
    end

    // Per-channel x4 decode of {A,B} prev -> cur, with index zeroing taking precedence
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cntNext[ch] = cnt[ch];
            dirNext[ch] = dir[ch];
            illegal[ch] = 1'b0;
            if (primed) begin
                case ({prevAb[ch], aSync[ch], bSync[ch]})
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                        cntNext[ch] = cnt[ch] + CNT_W'(1);
                        dirNext[ch] = 1'b0;
                    end
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                        cntNext[ch] = cnt[ch] - CNT_W'(1);
                        dirNext[ch] = 1'b1;
                    end
                    4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal[ch] = 1'b1;
                    default: ;
                endcase
                if (zSync[ch] && zero_en[ch]) cntNext[ch] = '0;
            end
        end
    end

    // Counter state; the first cycle out of reset only primes prevAb
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            primed <= 1'b0;
            dir    <= '0;
            err    <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                prevAb[ch] <= '0;
                cnt[ch]    <= '0;
            end
        end else begin
            primed <= 1'b1;
            dir    <= dirNext;
            err    <= (err & ~{NUM_CH{clr_flags}}) | illegal;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                prevAb[ch] <= {aSync[ch], bSync[ch]};
                cnt[ch]    <= cntNext[ch];
            end
        end
    end

    generate
        if (SAMPLE_DIV != 0) begin : gTimer
            localparam int               TMR_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
            localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
            logic [TMR_W-1:0] timer;

            // Free-running sample period counter, ticks on its last value
            always_ff @(posedge clk or negedge rstSyncN) begin
                if (!rstSyncN)             timer <= '0;
                else if (timer == TMR_LAST) timer <= '0;
                else                       timer <= timer + TMR_W'(1);
            end

            assign tick = (timer == TMR_LAST);
        end else begin : gNoTimer
            assign tick = 1'b0;
        end
    endgenerate

    assign trigger = sample_req | tick;

    // Scheduler state register
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) state <= IDLE;
        else           state <= stateNext;
    end

    // Scheduler next state and control strobes; any trigger outside IDLE is an overrun
    always_comb begin
        stateNext  = state;
        outValid   = 1'b0;
        loadSnap   = 1'b0;
        advance    = 1'b0;
        lastAccept = 1'b0;
        overrunSet = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) stateNext = SNAP;
            end
            SNAP: begin
                loadSnap   = 1'b1;
                overrunSet = trigger;
                stateNext  = SEND;
            end
            SEND: begin
                outValid   = 1'b1;
                overrunSet = trigger;
                if (outBus.out_ready) begin
                    if (idx == LAST_CH) begin
                        lastAccept = 1'b1;
                        stateNext  = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Snapshot capture (uses cntNext so a step decoded during SNAP is included), word index and flags
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            idx       <= '0;
            frameDone <= 1'b0;
            overrun   <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) snap[ch] <= '0;
        end else begin
            frameDone <= lastAccept;
            overrun   <= (overrun & ~clr_flags) | overrunSet;
            if (loadSnap) begin
                idx <= '0;
                for (int ch = 0; ch < NUM_CH; ch++) snap[ch] <= cntNext[ch];
            end else if (advance) begin
                idx <= idx + CH_W'(1);
            end
        end
    end

    assign outBus.out_valid  = outValid;
    assign outBus.out_data   = snap[idx];
    assign outBus.out_ch     = idx;
    assign outBus.frame_done = frameDone;
    assign busy              = (state != IDLE);
endmodule

// File: doc/quad_enc_ctrl.md
Name: quad_enc_ctrl

Overview:
Multi-channel quadrature encoder front end and readout scheduler.
- Synchronizes NUM_CH sets of A/B/Z pins and decodes them x4 into signed per-channel position counters.
- Snapshots all counters atomically on a periodic tick or a host request.
- Streams the snapshot one channel at a time over a valid/ready port to the Pi-side interface logic.

Parameters:
NUM_CH, 4, number of encoder channels (1..16)
CNT_W, 16, position counter width, two's complement
SAMPLE_DIV, 0, clock cycles per automatic snapshot; 0 disables the internal timer
CH_W (localparam), max(1, clog2(NUM_CH)), channel index width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enc_a  in  NUM_CH  encoder A pins, asynchronous
enc_b  in  NUM_CH  encoder B pins, asynchronous
enc_z  in  NUM_CH  encoder index pins, asynchronous
zero_en  in  NUM_CH  per-channel enable for Z zeroing
sample_req  in  1  one-cycle snapshot request
clr_flags  in  1  one-cycle clear of err and overrun
out_valid  out  1  snapshot word valid
out_ready  in  1  consumer accepts word
out_data  out  CNT_W  snapshot count of channel out_ch
out_ch  out  CH_W  channel index of out_data
frame_done  out  1  one-cycle pulse after last channel accepted
busy  out  1  high while in SNAP or SEND
dir  out  NUM_CH  last step direction: 0 = +1 (A leads), 1 = -1 (B leads)
err  out  NUM_CH  sticky illegal-transition flag
overrun  out  1  sticky trigger-while-busy flag

Behaviour:
Reset (async assert):
- All outputs 0, counters 0, synchronizers 0, state IDLE, timer 0, primed 0.
- Release is synchronous to clk; the design uses a 2-flop rst_n synchronizer for deassertion.

Input synchronization:
- Two flops per pin, plus a prev register holding the last decoded {A,B}.
- An edge stable before rising edge k is reflected in the count after edge k+2, i.e. 3-cycle latency.

Priming:
- The first cycle after reset release loads prev from the synchronizer output, with no count and no err.
- This prevents pins that are high at reset from flagging an error.

Decode ({A,B} prev -> cur):
- 00->10->11->01->00: +1, dir=0.
- Reverse sequence: -1, dir=1.
- No change: hold count and dir.
- Both bits change: count and dir unchanged, err[ch] set.

Count arithmetic:
- Modulo 2^CNT_W. The maximum positive value +1 wraps to the most negative value, and vice versa.

Zeroing:
- If the synchronized Z is high and zero_en[ch] is set, count <= 0 that cycle.
- Zeroing overrides any simultaneous step; dir is unaffected.
- err is still set if that cycle's transition is illegal.

Flags:
- clr_flags clears err and overrun.
- If clr_flags coincides with a new set condition, the set wins.

Timer:
- Active only when SAMPLE_DIV != 0. Free-runs 0..SAMPLE_DIV-1.
- Issues tick when the count equals SAMPLE_DIV-1.
- trigger = sample_req | tick.

Scheduler FSM:
- IDLE: on trigger go to SNAP.
- SNAP (1 cycle): latch all NUM_CH counters into snapshot regs in the same cycle (atomic), including any step decoded that cycle; idx <= 0; go to SEND.
- SEND:
  - out_valid=1, out_data=snap[idx], out_ch=idx.
  - out_data and out_ch are held stable while out_valid & !out_ready.
  - On handshake: if idx==NUM_CH-1, then out_valid <= 0, frame_done pulses, go to IDLE; else idx++.
- Trigger while in SNAP or SEND: dropped, overrun set, current frame unaffected.
- Trigger in the same cycle as the final handshake: also dropped, with overrun set.
- Counters keep updating during SEND; only the snapshot is streamed.
- busy = (state != IDLE).
- Reset mid-frame: frame abandoned, out_valid drops immediately (async).

Test Plan:
1. Ch0 forward, 10 full quadrature cycles (40 transitions, each held 4 clk), then sample_req -> frame of 4 words, ch0 out_data=40, others 0, dir[0]=0, frame_done one pulse after word 3.
2. Ch1 reverse 3 transitions from 0 -> snapshot ch1 = 16'hFFFD, dir[1]=1; ch1 preloaded to 16'h7FFF via forward steps then +1 -> 16'h8000.
3. Ch2 jumps 00->11 -> count unchanged, err[2]=1 and stays 1 until clr_flags pulse, then 0.
4. Ch3 at count 25, Z high with zero_en[3]=1 during a step -> count 0; repeat with zero_en[3]=0 -> count 26.
5. out_ready low 5 cycles mid-frame -> out_data/out_ch stable; sample_req during SEND -> overrun=1, frame still 4 words, no second frame.
6. SAMPLE_DIV=100, out_ready tied 1 -> SNAP every 100 cycles, busy high 5 cycles per frame; rst_n low during SEND -> out_valid=0 at once, first post-reset cycle primes with no err despite pins at 11.
